// File: rtl/fetch_pkg.sv
// fetch_pkg: shared entry type and instruction size for the fetch front end
package fetch_pkg;
    localparam int INST_BYTES = 4;
    localparam int FETCH_XLEN = 32;
    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] inst;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_if.sv
// fetch_if: memory request/response, redirect and decode handshakes of the fetch unit
interface fetch_if #(parameter int XLEN = 32);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst_data;
    logic [XLEN-1:0] inst_pc;
    modport master (
        output imem_req, imem_addr, inst_valid, inst_data, inst_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
    );
    modport slave (
        input  imem_req, imem_addr, inst_valid, inst_data, inst_pc,
        output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous flushable FIFO; pointers carry one extra bit to tell full from empty
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                         CLK,
    input  logic                         RSTa,
    input  logic                         flush,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr, rptr;
    logic             do_push, do_pop;
    always_comb begin
        count   = CW'(wptr - rptr);
        do_pop  = pop && count != '0;
        do_push = push && (count != CW'(DEPTH) || do_pop);
        dout    = mem[rptr[AW-1:0]];
    end
    always_ff @(posedge CLK) begin
        if (RSTa || flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop) rptr <= rptr + 1'b1;
        end
    end
    always_ff @(posedge CLK)
        if (do_push) mem[wptr[AW-1:0]] <= din;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch with prefetch queue, credit flow control and redirect flush
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input logic     CLK,
    input logic     RSTa,
    fetch_if.master bus
);
    localparam int              CW    = $clog2(DEPTH+1);
    localparam logic [XLEN-1:0] STEP  = XLEN'(INST_BYTES);
    localparam logic [XLEN-1:0] ALIGN = ~XLEN'(INST_BYTES - 1);
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } entry_t;
    logic [XLEN-1:0] fetch_pc, resp_pc, target;
    logic [CW-1:0]   count, inflight, discard, inflight_left;
    logic [CW:0]     credit_used;
    logic            fire, drop, push, pop;
    entry_t          head;
    always_comb begin
        target         = bus.redirect_pc & ALIGN;
        credit_used    = {1'b0, count} + {1'b0, inflight};
        bus.imem_req   = !RSTa && !bus.redirect_valid && credit_used < (CW+1)'(DEPTH);
        bus.imem_addr  = fetch_pc;
        bus.inst_valid = !RSTa && !bus.redirect_valid && count != '0;
        bus.inst_pc    = head.pc;
        bus.inst_data  = head.inst;
        fire           = bus.imem_req && bus.imem_gnt;
        drop           = discard != '0;
        push           = bus.imem_rvalid && !drop && !bus.redirect_valid;
        pop            = bus.inst_valid && bus.inst_ready;
        inflight_left  = inflight - CW'(bus.imem_rvalid);
    end
    // every response still outstanding at a redirect belongs to the old stream
    always_ff @(posedge CLK) begin
        if (RSTa) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            inflight <= '0;
            discard  <= '0;
        end else begin
            inflight <= inflight_left + CW'(fire);
            if (bus.redirect_valid) begin
                fetch_pc <= target;
                resp_pc  <= target;
                discard  <= inflight_left;
            end else begin
                if (fire) fetch_pc <= fetch_pc + STEP;
                if (push) resp_pc <= resp_pc + STEP;
                if (bus.imem_rvalid && drop) discard <= discard - 1'b1;
            end
        end
    end
    always_ff @(posedge CLK)
        if (!RSTa) assert (!(bus.imem_rvalid && inflight == '0));
    fetch_fifo #(.DEPTH(DEPTH), .WIDTH($bits(entry_t))) u_fifo (
        .CLK   (CLK),
        .RSTa  (RSTa),
        .flush (bus.redirect_valid),
        .push  (push),
        .pop   (pop),
        .din   ({resp_pc, bus.imem_rdata}),
        .dout  (head),
        .count (count)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and soak checks of fetch_unit against an in-order, latency-programmable memory
module tb_fetch_unit;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    logic CLK  = 1'b0;
    logic RSTa = 1'b1;
    always #5 CLK = ~CLK;
    fetch_if #(.XLEN(XLEN)) bus ();
    fetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h100)) dut (
        .CLK  (CLK),
        .RSTa (RSTa),
        .bus  (bus.master)
    );
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          lat = 1;
    int          grants = 0;
    bit          rand_lat = 1'b0;
    logic        s_req = 1'b0, s_gnt = 1'b0, s_rv = 1'b0;
    logic [31:0] s_addr = '0;
    logic [31:0] pend_a[$];
    int          pend_d[$];
    logic [31:0] exp_pc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!bus.inst_valid && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk(tag, bus.inst_valid, 1);
    endtask

    task automatic quiesce(input logic [31:0] pc);
        next();
        bus.imem_gnt       = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = pc;
        next();
        bus.redirect_valid = 1'b0;
        repeat (6) next();
    endtask

    // sample what the DUT will see at the coming edge, well after all input updates
    always @(negedge CLK) begin
        #2;
        s_req  = bus.imem_req;
        s_gnt  = bus.imem_gnt;
        s_rv   = bus.imem_rvalid;
        s_addr = bus.imem_addr;
    end

    always @(posedge CLK) begin
        cyc++;
        if (RSTa) begin
            pend_a.delete();
            pend_d.delete();
        end else begin
            if (s_rv) begin
                void'(pend_a.pop_front());
                void'(pend_d.pop_front());
            end
            if (s_req && s_gnt) begin
                grants++;
                pend_a.push_back(s_addr);
                pend_d.push_back(cyc + (rand_lat ? int'($urandom_range(4, 1)) : lat) - 1);
            end
        end
        #1;
        bus.imem_rvalid = (pend_a.size() != 0) ? (pend_d[0] <= cyc) : 1'b0;
        bus.imem_rdata  = (pend_a.size() != 0) ? pend_a[0] : '0;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.imem_gnt       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.inst_ready     = 1'b0;
        @(negedge CLK);
        chk("rst_req", bus.imem_req, 0);
        chk("rst_valid", bus.inst_valid, 0);
        next();
        RSTa           = 1'b0;
        bus.imem_gnt   = 1'b1;
        bus.inst_ready = 1'b1;
        @(negedge CLK);
        chk("post_rst_req", bus.imem_req, 1);
        chk("post_rst_addr", bus.imem_addr, 32'h100);
        repeat (2) @(negedge CLK);
        for (int i = 0; i < 6; i++) begin
            chk("stream_valid", bus.inst_valid, 1);
            chk("stream_pc", bus.inst_pc, 32'h100 + 32'(4 * i));
            chk("stream_data", bus.inst_data, 32'h100 + 32'(4 * i));
            @(negedge CLK);
        end

        next();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        bus.inst_ready     = 1'b0;
        grants             = 0;
        next();
        bus.redirect_valid = 1'b0;
        repeat (8) @(negedge CLK);
        chk("stall_grants", 32'(grants), 4);
        chk("stall_req", bus.imem_req, 0);
        chk("stall_addr", bus.imem_addr, 32'h110);
        chk("stall_head", bus.inst_pc, 32'h100);
        next();
        bus.inst_ready = 1'b1;
        @(negedge CLK);
        chk("pop_cycle_req", bus.imem_req, 0);
        next();
        bus.inst_ready = 1'b0;
        @(negedge CLK);
        chk("refill_req", bus.imem_req, 1);
        chk("refill_addr", bus.imem_addr, 32'h110);
        chk("refill_head", bus.inst_pc, 32'h104);

        quiesce(32'h180);
        lat            = 3;
        bus.imem_gnt   = 1'b1;
        bus.inst_ready = 1'b1;
        next();
        next();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h200;
        @(negedge CLK);
        chk("redir_req", bus.imem_req, 0);
        chk("redir_valid", bus.inst_valid, 0);
        next();
        bus.redirect_valid = 1'b0;
        @(negedge CLK);
        chk("redir_addr", bus.imem_addr, 32'h200);
        chk("redir_req_on", bus.imem_req, 1);
        wait_valid("redir_first_valid");
        chk("redir_first_pc", bus.inst_pc, 32'h200);
        chk("redir_first_data", bus.inst_data, 32'h200);

        begin
            int n = 0;
            while (!(bus.imem_rvalid && bus.inst_valid) && n < 20) begin
                @(negedge CLK);
                n++;
            end
        end
        chk("edge_setup", bus.imem_rvalid && bus.inst_valid, 1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h303;
        #1;
        chk("edge_valid_forced", bus.inst_valid, 0);
        chk("edge_req", bus.imem_req, 0);
        @(posedge CLK);
        #1;
        bus.redirect_valid = 1'b0;
        @(negedge CLK);
        chk("edge_flushed", bus.inst_valid, 0);
        chk("edge_addr", bus.imem_addr, 32'h300);
        wait_valid("edge_first_valid");
        chk("edge_first_pc", bus.inst_pc, 32'h300);

        quiesce(32'h0);
        lat                = 1;
        bus.imem_gnt       = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        next();
        bus.redirect_valid = 1'b0;
        @(negedge CLK);
        chk("wrap_addr0", bus.imem_addr, 32'hFFFF_FFFC);
        @(negedge CLK);
        chk("wrap_addr1", bus.imem_addr, 32'h0);
        wait_valid("wrap_valid");
        chk("wrap_pc0", bus.inst_pc, 32'hFFFF_FFFC);
        @(negedge CLK);
        chk("wrap_valid1", bus.inst_valid, 1);
        chk("wrap_pc1", bus.inst_pc, 32'h0);
        chk("wrap_data1", bus.inst_data, 32'h0);

        rand_lat = 1'b1;
        next();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h1000;
        exp_pc             = 32'h1000;
        for (int c = 0; c < 3000; c++) begin
            next();
            bus.redirect_valid = ($urandom_range(39, 0) == 0);
            bus.redirect_pc    = $urandom;
            bus.imem_gnt       = 1'($urandom_range(1, 0));
            bus.inst_ready     = ($urandom_range(3, 0) != 0);
            @(negedge CLK);
            if (bus.inst_valid && bus.inst_ready) begin
                chk("soak_pc", bus.inst_pc, exp_pc);
                chk("soak_data", bus.inst_data, exp_pc);
                exp_pc = exp_pc + 32'd4;
            end
            chk("soak_credit", int'(dut.count) + int'(dut.inflight) <= DEPTH, 1);
            if (bus.redirect_valid) exp_pc = bus.redirect_pc & 32'hFFFF_FFFC;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
